// File: rtl/control_pipe.sv
// Pipeline control unit: opcode decode, ID/EX -> EX/MEM -> MEM/WB control
// staging, load-use hazard stall generation and a saturating stall counter.
module control_pipe #(
  parameter int REG_AW     = 5,
  parameter int EXT_OPS    = 1,
  parameter int LOAD_STALL = 1,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              flush,
  output logic              stall,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic [1:0]        ex_ALUOp,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic              mem_Branch,
  output logic              mem_BranchNe,
  output logic              mem_Jump,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [1:0] STALL_LOAD = 2'(LOAD_STALL - 1);

  // Low 7 bits (mem + wb fields) are what travels on past ID/EX.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  ctrl_t             dec_s, idex_q, idex_d;
  logic [REG_AW-1:0] idex_rt_q, idex_rt_d;
  logic [6:0]        exmem_q, exmem_d;
  logic [1:0]        memwb_q, memwb_d;
  logic [1:0]        scnt_q, scnt_d;
  logic [PERF_W-1:0] perf_q, perf_d;
  logic              rt_used_s, detect_s, stall_s;

  // Opcode decode; anything unrecognised or invalid is a bubble.
  always_comb begin
    dec_s = '0;
    if (id_valid) begin
      case (id_opcode)
        OP_R:   begin dec_s.reg_dst = 1'b1; dec_s.reg_write = 1'b1; dec_s.alu_op = 2'b10; end
        OP_LW:  begin dec_s.alu_src = 1'b1; dec_s.mem_to_reg = 1'b1; dec_s.reg_write = 1'b1;
                      dec_s.mem_read = 1'b1; dec_s.alu_op = 2'b00; end
        OP_SW:  begin dec_s.alu_src = 1'b1; dec_s.mem_write = 1'b1; dec_s.alu_op = 2'b00; end
        OP_BEQ: begin dec_s.branch = 1'b1; dec_s.alu_op = 2'b01; end
        OP_ADDI: begin
          if (EXT_OPS != 0) begin
            dec_s.alu_src = 1'b1; dec_s.reg_write = 1'b1; dec_s.alu_op = 2'b00;
          end else begin
            dec_s = '0;
          end
        end
        OP_BNE: begin
          if (EXT_OPS != 0) begin
            dec_s.branch = 1'b1; dec_s.branch_ne = 1'b1; dec_s.alu_op = 2'b01;
          end else begin
            dec_s = '0;
          end
        end
        OP_J: begin
          if (EXT_OPS != 0) begin
            dec_s.jump = 1'b1;
          end else begin
            dec_s = '0;
          end
        end
        default: dec_s = '0;
      endcase
    end else begin
      dec_s = '0;
    end
  end

  // Load-use hazard detection and stall request; flush always wins.
  always_comb begin
    rt_used_s = (id_opcode == OP_R) || (id_opcode == OP_SW) ||
                (id_opcode == OP_BEQ) || (id_opcode == OP_BNE);
    detect_s  = idex_q.mem_read && (idex_rt_q != '0) && id_valid &&
                ((idex_rt_q == id_rs) || ((idex_rt_q == id_rt) && rt_used_s));
    stall_s   = !flush && (detect_s || (scnt_q != 2'd0));
  end

  // Next state of the stage registers, stall counter and perf counter.
  always_comb begin
    memwb_d = exmem_q[1:0];
    if (flush) begin
      idex_d    = '0;
      idex_rt_d = '0;
      exmem_d   = 7'd0;
    end else if (stall_s) begin
      idex_d    = '0;
      idex_rt_d = '0;
      exmem_d   = idex_q[6:0];
    end else begin
      idex_d    = dec_s;
      idex_rt_d = id_rt;
      exmem_d   = idex_q[6:0];
    end

    if (flush) begin
      scnt_d = 2'd0;
    end else if (scnt_q != 2'd0) begin
      scnt_d = scnt_q - 2'd1;
    end else if (detect_s) begin
      scnt_d = STALL_LOAD;
    end else begin
      scnt_d = scnt_q;
    end

    if (stall_s && (perf_q != {PERF_W{1'b1}})) begin
      perf_d = perf_q + PERF_W'(1);
    end else begin
      perf_d = perf_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q    <= '0;
      idex_rt_q <= '0;
      exmem_q   <= 7'd0;
      memwb_q   <= 2'd0;
      scnt_q    <= 2'd0;
      perf_q    <= '0;
    end else begin
      idex_q    <= idex_d;
      idex_rt_q <= idex_rt_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      scnt_q    <= scnt_d;
      perf_q    <= perf_d;
    end
  end

  assign stall        = stall_s;
  assign ex_RegDst    = idex_q.reg_dst;
  assign ex_ALUSrc    = idex_q.alu_src;
  assign ex_ALUOp     = idex_q.alu_op;
  assign mem_MemRead  = exmem_q[6];
  assign mem_MemWrite = exmem_q[5];
  assign mem_Branch   = exmem_q[4];
  assign mem_BranchNe = exmem_q[3];
  assign mem_Jump     = exmem_q[2];
  assign wb_RegWrite  = memwb_q[1];
  assign wb_MemtoReg  = memwb_q[0];
  assign stall_cnt    = perf_q;

endmodule
